// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared constants and types for the SPI-attached RAM block:
//                command opcodes, default widths and the sequencing state.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

  // Default widths of the command word coming from the SPI slave
  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  // Opcodes carried in din[9:8]
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Sequencing state; bit 0 is the write-armed flag, bit 1 the read-armed
  // flag, so both sides can be armed at once without extra states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_WR_ADDR_DONE = 2'b01,
    ST_RD_ADDR_DONE = 2'b10,
    ST_BOTH_DONE    = 2'b11
  } seq_state_e;

  // Build a state value from the two armed flags
  function automatic seq_state_e arm_state(input logic wr_armed, input logic rd_armed);
    return seq_state_e'({rd_armed, wr_armed});
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_sp_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_core
//  Description : Plain single-port synchronous RAM. Writes on we_i, registered
//                read on re_i; read data holds between reads. Only the read
//                register is reset, never the array.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_core #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read; cleared by reset and held until the next read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/spi_ram.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram
//  Description : RAM downstream of the SPI slave. Decodes 10-bit rx words
//                (2-bit opcode + 8-bit payload) into write-address, write-data,
//                read-address and read-data operations; read bytes return on
//                dout with a one-cycle tx_valid pulse, order violations raise a
//                one-cycle cmd_err pulse.
//                Build option SPI_RAM_AUTO_INC_EN: post-increment the write and
//                read addresses after each successful data access.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              cmd_err
);

  // Addresses must cover the array exactly so the payload can never overrun it
  if (MEM_DEPTH != 2**ADDR_SIZE) begin : g_bad_depth
    $error("spi_ram: MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  logic [1:0]           op;
  logic [ADDR_SIZE-1:0] addr_payload;
  logic [DATA_W-1:0]    data_payload;

  seq_state_e           state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 tx_valid_q;
  logic                 cmd_err_q;

  logic                 wr_armed, rd_armed;
  logic                 is_wr_addr, is_wr_data, is_rd_addr, is_rd_data;
  logic                 wr_ok, rd_ok, order_err;
  logic                 ram_we, ram_re;
  logic [ADDR_SIZE-1:0] ram_addr;

  assign op           = din[CMD_W-1 -: 2];
  assign addr_payload = din[ADDR_SIZE-1:0];
  assign data_payload = din[DATA_W-1:0];

  assign wr_armed = (state_q == ST_WR_ADDR_DONE) || (state_q == ST_BOTH_DONE);
  assign rd_armed = (state_q == ST_RD_ADDR_DONE) || (state_q == ST_BOTH_DONE);

  // Command decode qualified by rx_valid, plus next-state for addresses/flags
  always_comb begin
    is_wr_addr = rx_valid && (op == OP_WR_ADDR);
    is_wr_data = rx_valid && (op == OP_WR_DATA);
    is_rd_addr = rx_valid && (op == OP_RD_ADDR);
    is_rd_data = rx_valid && (op == OP_RD_DATA);

    wr_ok     = is_wr_data && wr_armed;
    rd_ok     = is_rd_data && rd_armed;
    order_err = (is_wr_data && !wr_armed) || (is_rd_data && !rd_armed);

    // Flags only ever set; nothing but reset disarms a side
    state_d = arm_state(wr_armed || is_wr_addr, rd_armed || is_rd_addr);

    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (is_wr_addr) begin
      wr_addr_d = addr_payload;
    end
`ifdef SPI_RAM_AUTO_INC_EN
    else if (wr_ok) begin
      wr_addr_d = wr_addr_q + 1'b1;   // wraps MEM_DEPTH-1 -> 0
    end
`endif
    if (is_rd_addr) begin
      rd_addr_d = addr_payload;
    end
`ifdef SPI_RAM_AUTO_INC_EN
    else if (rd_ok) begin
      rd_addr_d = rd_addr_q + 1'b1;   // wraps MEM_DEPTH-1 -> 0
    end
`endif
  end

  // Sequencing FSM with address registers and registered status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= rd_ok;
      cmd_err_q  <= order_err;
    end
  end

  // One access per cycle, so a single port muxed on the opcode suffices.
  // Gating with rst_n makes a command on a reset edge a no-op.
  assign ram_we   = wr_ok && rst_n;
  assign ram_re   = rd_ok && rst_n;
  assign ram_addr = is_rd_data ? rd_addr_q : wr_addr_q;

  sp_ram_core #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_SIZE),
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (data_payload),
    .rdata_o (dout)
  );

  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule
`default_nettype wire
